// File: rtl/bus_arbiter_mux_if.sv
// Bus interface for the round-robin arbiter/mux. The slave modport is
// the arbiter side, and the master modport is the side that supplies
// requests and source words.
interface bus_arbiter_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 8
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]            req;
    logic [NUM_SRC*DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0]         BusMuxOut;
    logic                          bus_valid;
    logic [NUM_SRC-1:0]            grant;
    logic [SRC_W-1:0]              src_id;
    logic                          busy;
    logic [15:0]                   xfer_count;

    // Arbiter side.
    modport slave (
        input  req,
        input  bus_in,
        output BusMuxOut,
        output bus_valid,
        output grant,
        output src_id,
        output busy,
        output xfer_count
    );

    // Requester / environment side.
    modport master (
        output req,
        output bus_in,
        input  BusMuxOut,
        input  bus_valid,
        input  grant,
        input  src_id,
        input  busy,
        input  xfer_count
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter and output mux. Each transfer takes exactly three
// cycles:
//   - IDLE samples the requests and picks a winner.
//   - GRANT latches the winner's word onto the bus.
//   - DRIVE presents bus_valid for one cycle, then moves the round-robin
//     pointer past the winner.
module bus_arbiter_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 8
) (
    input  logic              clock,
    input  logic              clear,
    bus_arbiter_mux_if.slave  bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [SRC_W:0] LP_NUM = (SRC_W+1)'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                r_state;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [SRC_W-1:0]      r_src_id;
    logic [NUM_SRC-1:0]    r_grant;
    logic [DATA_WIDTH-1:0] r_bus_out;
    logic                  r_bus_valid;
    logic                  r_busy;
    logic [15:0]           r_xfer_count;

    // Source words unpacked from the flattened input bus.
    logic [DATA_WIDTH-1:0] w_words [NUM_SRC];

    // Requests rotated so that bit 0 is the source at r_rr_ptr.
    logic [2*NUM_SRC-1:0]  w_req_dbl;
    logic [NUM_SRC-1:0]    w_req_rot;
    logic [NUM_SRC-1:0]    w_first;
    logic [SRC_W-1:0]      w_offset;
    logic [SRC_W:0]        w_win_sum;
    logic [SRC_W:0]        w_win_wrap;
    logic [SRC_W-1:0]      w_winner;
    logic [NUM_SRC-1:0]    w_win_onehot;
    logic [SRC_W:0]        w_nxt_sum;
    logic [SRC_W:0]        w_nxt_wrap;
    logic [SRC_W-1:0]      w_next_ptr;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_words
            assign w_words[gi] = bus.bus_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Doubling the request vector lets a plain part-select perform the rotation.
    assign w_req_dbl = {bus.req, bus.req};
    assign w_req_rot = w_req_dbl[r_rr_ptr +: NUM_SRC];

    // Isolate the lowest set bit of the rotated request vector.
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign w_first[gi] = w_req_rot[gi];
            end else begin : g_upper
                assign w_first[gi] = w_req_rot[gi] & ~(|w_req_rot[gi-1:0]);
            end
        end
    endgenerate

    // Encode the one-hot first-set mask into an offset from r_rr_ptr.
    always_comb begin
        w_offset = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_first[k]) begin
                w_offset = w_offset | SRC_W'(k);
            end
        end
    end

    // Convert the offset back to an absolute index, modulo NUM_SRC.
    assign w_win_sum    = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_win_wrap   = w_win_sum - LP_NUM;
    assign w_winner     = (w_win_sum >= LP_NUM) ? w_win_wrap[SRC_W-1:0]
                                                : w_win_sum[SRC_W-1:0];
    assign w_win_onehot = NUM_SRC'(1) << w_winner;

    // The pointer moves one place past the winner once its transfer completes.
    assign w_nxt_sum  = {1'b0, r_src_id} + (SRC_W+1)'(1);
    assign w_nxt_wrap = w_nxt_sum - LP_NUM;
    assign w_next_ptr = (w_nxt_sum >= LP_NUM) ? w_nxt_wrap[SRC_W-1:0]
                                              : w_nxt_sum[SRC_W-1:0];

    // Arbitration FSM with all outputs registered.
    // clear overrides everything, which also aborts an in-flight transfer.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_src_id     <= '0;
            r_grant      <= '0;
            r_bus_out    <= '0;
            r_bus_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            // The counter is rewritten every cycle. It only advances on DRIVE
            // exit and wraps silently.
            r_xfer_count <= r_xfer_count + {15'd0, (r_state == ST_DRIVE)};
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_grant  <= w_win_onehot;
                        r_src_id <= w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Requests are ignored from here until the next IDLE.
                    r_bus_out   <= w_words[r_src_id];
                    r_bus_valid <= 1'b1;
                    r_state     <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    r_bus_valid <= 1'b0;
                    r_grant     <= '0;
                    r_rr_ptr    <= w_next_ptr;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_grant     <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.BusMuxOut  = r_bus_out;
    assign bus.bus_valid  = r_bus_valid;
    assign bus.grant      = r_grant;
    assign bus.src_id     = r_src_id;
    assign bus.busy       = r_busy;
    assign bus.xfer_count = r_xfer_count;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux.
// A transaction-level reference model tracks each transfer window and pushes
// the expected bus word into a scoreboard. A monitor pops that scoreboard
// whenever bus_valid is seen. Directed scenarios come first, followed by
// randomized traffic.
module tb_bus_arbiter_mux;
    localparam int DW = 32;
    localparam int NS = 8;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    bus_arbiter_mux_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bif ();

    bus_arbiter_mux #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    typedef struct {
        int          src;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   seen[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    // Reference model state
    bit          m_active = 1'b0;
    int          m_start  = 0;
    int          m_ptr    = 0;
    int          m_src    = 0;
    logic [15:0] m_cnt    = '0;
    logic [31:0] m_bus    = '0;
    logic [7:0]  m_grant  = '0;
    int          pre_seq  = 0;
    int          pre_done = 0;
    logic [15:0] pre_val  = '0;

    function automatic logic [31:0] word_of(logic [NS*DW-1:0] v, int i);
        return v[i*DW +: DW];
    endfunction

    // Round-robin rule: first requester at or after ptr, wrapping around.
    function automatic int rr_pick(logic [7:0] r, int ptr);
        for (int k = 0; k < NS; k++) begin
            if (r[(ptr + k) % NS]) return (ptr + k) % NS;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: each transfer occupies edges start, start+1, start+2.
    always @(posedge clock) begin
        cyc++;
        if (clear) begin
            m_active = 1'b0;
            m_ptr    = 0;
            m_src    = 0;
            m_cnt    = '0;
            m_bus    = '0;
            m_grant  = '0;
        end else begin
            if (pre_seq != pre_done) begin
                m_cnt    = pre_val;
                pre_done = pre_seq;
            end
            if (m_active) begin
                if (cyc == m_start + 1) begin
                    m_bus = word_of(bif.bus_in, m_src);
                    sb.push_back('{m_src, m_bus, cyc});
                end else begin
                    m_cnt    = m_cnt + 16'd1;
                    m_ptr    = (m_src + 1) % NS;
                    m_grant  = '0;
                    m_active = 1'b0;
                end
            end else if (bif.req != '0) begin
                m_src    = rr_pick(bif.req, m_ptr);
                m_grant  = 8'(1 << m_src);
                m_start  = cyc;
                m_active = 1'b1;
            end
        end
    end

    // Monitor: per-cycle checks plus scoreboard pop on every bus_valid.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("grant", bif.grant, m_grant);
            chk("onehot", 64'($countones(bif.grant) <= 1), 64'd1);
            chk("busy", bif.busy, m_active);
            chk("xfer_count", bif.xfer_count, m_cnt);
            chk("src_id", bif.src_id, m_src);
            chk("bus_hold", bif.BusMuxOut, m_bus);
            chk("valid", bif.bus_valid, (m_active && cyc == m_start + 1));
            if (bif.bus_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_src", bif.src_id, e.src);
                    chk("sb_word", bif.BusMuxOut, e.word);
                    chk("sb_cycle", cyc, e.cyc);
                    $display("xfer cyc=%0d src=%0d word=%08h count=%0d",
                             cyc, bif.src_id, bif.BusMuxOut, bif.xfer_count);
                end
                seen.push_back(int'(bif.src_id));
            end
        end
    end

    task automatic rand_words();
        for (int i = 0; i < NS; i++) bif.bus_in[i*DW +: DW] = $urandom();
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear   = 1'b1;
        bif.req = '0;
        @(negedge clock);
        clear   = 1'b0;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int base;
        bif.req = '0;
        rand_words();
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1 chk_en = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("rst_count", bif.xfer_count, 16'h0000);
        chk("rst_grant", bif.grant, 8'h00);

        // Single request from source 2.
        bif.bus_in[2*DW +: DW] = 32'hDEADBEEF;
        bif.req = 8'h04;
        wait_cyc(1);
        bif.req = 8'h00;
        chk("single_grant", bif.grant, 8'h04);
        wait_cyc(1);
        chk("single_valid", bif.bus_valid, 1'b1);
        chk("single_word", bif.BusMuxOut, 32'hDEADBEEF);
        wait_cyc(1);
        chk("single_busy", bif.busy, 1'b0);
        chk("single_count", bif.xfer_count, 16'd1);
        wait_cyc(2);

        // Round-robin between sources 0 and 7.
        do_clear();
        bif.bus_in[0*DW +: DW] = 32'h11111111;
        bif.bus_in[7*DW +: DW] = 32'h77777777;
        base = seen.size();
        bif.req = 8'h81;
        wait_cyc(12);
        bif.req = 8'h00;
        wait_cyc(3);
        chk("rr_n", seen.size() - base, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", seen[base + k], (k % 2 == 0) ? 0 : 7);

        // All sources requesting.
        do_clear();
        rand_words();
        base = seen.size();
        bif.req = 8'hFF;
        wait_cyc(24);
        bif.req = 8'h00;
        wait_cyc(3);
        chk("all_n", seen.size() - base, 8);
        for (int k = 0; k < 8; k++) chk("all_order", seen[base + k], k);

        // Request dropped during GRANT still completes.
        do_clear();
        bif.bus_in[1*DW +: DW] = 32'hA5A51111;
        bif.req = 8'h02;
        wait_cyc(1);
        bif.req = 8'h00;
        wait_cyc(5);
        chk("drop_word", bif.BusMuxOut, 32'hA5A51111);
        chk("drop_busy", bif.busy, 1'b0);
        chk("drop_count", bif.xfer_count, 16'd1);

        // Clear while source 5 is in DRIVE, with the pointer non-zero beforehand.
        do_clear();
        bif.req = 8'h04;
        wait_cyc(1);
        bif.req = 8'h00;
        wait_cyc(3);
        bif.req = 8'h20;
        wait_cyc(1);
        bif.req = 8'h00;
        wait_cyc(1);
        chk("abort_in_drive", bif.src_id, 3'd5);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        chk("abort_count", bif.xfer_count, 16'd0);
        chk("abort_grant", bif.grant, 8'h00);
        chk("abort_bus", bif.BusMuxOut, 32'h0);
        bif.req = 8'h12;
        wait_cyc(1);
        bif.req = 8'h00;
        chk("abort_rr_src", bif.src_id, 3'd1);
        wait_cyc(4);

        // Counter wrap via a preload of the count register.
        @(posedge clock);
        #1 chk_en = 1'b0;
        @(negedge clock);
        force dut.r_xfer_count = 16'hFFFE;
        pre_val = 16'hFFFE;
        pre_seq++;
        @(negedge clock);
        release dut.r_xfer_count;
        #1 chk_en = 1'b1;
        bif.req = 8'h01;
        wait_cyc(6);
        bif.req = 8'h00;
        wait_cyc(2);
        chk("wrap_count", bif.xfer_count, 16'h0000);

        // Randomized traffic with occasional clears.
        for (int t = 0; t < 900; t++) begin
            @(negedge clock);
            rand_words();
            bif.req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            clear   = ($urandom_range(0, 59) == 0);
        end
        @(negedge clock);
        clear   = 1'b0;
        bif.req = 8'h00;
        wait_cyc(6);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
